// File: rtl/oam_dma_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : mem_if
// Description : Shared BRAM-region memory bus. The master drives address,
//               write data and write strobe; the addressed slave returns
//               registered read data one cycle after the address.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface mem_if;
    logic [15:0] addr_select;
    logic [7:0]  write_value;
    logic        write_enable;
    logic [7:0]  read_out;

    modport master (
        output addr_select,
        output write_value,
        output write_enable,
        input  read_out
    );

    modport slave (
        input  addr_select,
        input  write_value,
        input  write_enable,
        output read_out
    );
endinterface
`default_nettype wire

// File: rtl/oam_dma.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : oam_dma
// Description : Sprite-attribute DMA. On a 0xFF46 write it copies LEN bytes
//               from the selected source page (echo RAM remapped to work RAM)
//               into OAM at DST_BASE, one byte every three cycles (RD, CAP,
//               WR). Optional macro OAM_DMA_RESTART_EN lets a trigger while
//               busy restart the copy from byte 0.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module oam_dma #(
    parameter int          LEN      = 160,
    parameter logic [15:0] DST_BASE = 16'hFE00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trig,
    input  logic [7:0] trig_page,
    mem_if.master      bus,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_rd    = 2'd1;
    localparam logic [1:0] c_st_cap   = 2'd2;
    localparam logic [1:0] c_st_wr    = 2'd3;
    localparam logic [7:0] c_last_idx = 8'(LEN - 1);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [7:0] r_idx;
    logic [7:0] w_idx_nxt;
    logic [7:0] r_src_hi;
    logic [7:0] w_src_hi_nxt;
    logic [7:0] r_data_q;
    logic       r_done;
    logic       w_done_nxt;
    logic [7:0] w_remap_page;
    logic       w_restart;

    // Echo RAM pages 0xE0-0xFF alias work RAM 0x20 pages lower
    assign w_remap_page = (trig_page >= 8'hE0) ? (trig_page - 8'h20) : trig_page;

`ifdef OAM_DMA_RESTART_EN
    assign w_restart = trig && (r_state != c_st_idle);
`else
    assign w_restart = 1'b0;
`endif

    // State, byte index, source page and done pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_st_idle;
            r_idx    <= 8'd0;
            r_src_hi <= 8'd0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_src_hi <= w_src_hi_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // Capture the slave's registered read data during CAP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_q <= 8'd0;
        end else if (r_state == c_st_cap) begin
            r_data_q <= bus.read_out;
        end
    end

    // Next-state logic; a restart overrides everything, including the done pulse
    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_src_hi_nxt = r_src_hi;
        w_done_nxt   = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (trig) begin
                    w_src_hi_nxt = w_remap_page;
                    w_idx_nxt    = 8'd0;
                    w_state_nxt  = c_st_rd;
                end
            end
            c_st_rd:  w_state_nxt = c_st_cap;
            c_st_cap: w_state_nxt = c_st_wr;
            c_st_wr: begin
                if (r_idx == c_last_idx) begin
                    w_state_nxt = c_st_idle;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_idx_nxt   = r_idx + 8'd1;
                    w_state_nxt = c_st_rd;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
        if (w_restart) begin
            w_src_hi_nxt = w_remap_page;
            w_idx_nxt    = 8'd0;
            w_state_nxt  = c_st_rd;
            w_done_nxt   = 1'b0;
        end
    end

    // Bus outputs decoded from registered state only; destination low byte wraps without carry
    always_comb begin
        bus.addr_select  = 16'h0000;
        bus.write_value  = 8'h00;
        bus.write_enable = 1'b0;
        case (r_state)
            c_st_rd, c_st_cap: begin
                bus.addr_select = {r_src_hi, r_idx};
            end
            c_st_wr: begin
                bus.addr_select  = {DST_BASE[15:8], DST_BASE[7:0] + r_idx};
                bus.write_value  = r_data_q;
                bus.write_enable = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy = (r_state != c_st_idle);
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_oam_dma.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// Module      : tb_oam_dma
// Description : Self-checking bench for oam_dma with a registered-read memory
//               model, a write scoreboard and table-driven transfer vectors.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_oam_dma;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        logic [7:0] page;     // value written to 0xFF46
        logic [7:0] src;      // page the copy must read from
        logic [7:0] xorv;     // source pattern: byte i = i ^ xorv
    } vec_t;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       trig      = 1'b0;
    logic [7:0] trig_page = 8'h00;
    logic       busy;
    logic       done;

    logic        tb_we   = 1'b0;
    logic [15:0] tb_addr = 16'h0000;
    logic [7:0]  tb_data = 8'h00;

    logic [7:0] mem [0:65535];
    logic [7:0] exp_oam [0:159];

    wr_t  sb_q [$];
    wr_t  sb_e;
    int   n_checks   = 0;
    int   n_pass     = 0;
    int   echo_hits  = 0;
    logic watch_en   = 1'b0;
    logic [7:0] watch_page = 8'h00;

    mem_if bus ();

    oam_dma #(
        .LEN      (160),
        .DST_BASE (16'hFE00)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .trig      (trig),
        .trig_page (trig_page),
        .bus       (bus),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Memory slave: registered read, write on rising edge, plus a bench preload port
    always @(posedge clk) begin
        bus.read_out <= mem[bus.addr_select];
        if (bus.write_enable) mem[bus.addr_select] <= bus.write_value;
        if (tb_we) mem[tb_addr] <= tb_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Write monitor: every presented write is matched against the scoreboard
    always @(negedge clk) begin
        if (watch_en && busy && bus.addr_select[15:8] == watch_page) echo_hits++;
        if (bus.write_enable === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                         bus.addr_select, bus.write_value);
            end else begin
                sb_e = sb_q.pop_front();
                check("bus_write", {8'h00, bus.addr_select, bus.write_value},
                      {8'h00, sb_e.addr, sb_e.data});
            end
        end
    end

    task automatic fill(input logic [7:0] page, input logic [7:0] xorv);
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            tb_we   = 1'b1;
            tb_addr = {page, 8'(i)};
            tb_data = 8'(i) ^ xorv;
        end
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic push_bytes(input logic [7:0] xorv, input int n, input logic set_oam);
        for (int i = 0; i < n; i++) begin
            sb_q.push_back({16'hFE00 + 16'(i), 8'(i) ^ xorv});
            if (set_oam) exp_oam[i] = 8'(i) ^ xorv;
        end
    endtask

    task automatic trigger(input logic [7:0] page);
        @(negedge clk);
        trig      = 1'b1;
        trig_page = page;
        @(negedge clk);
        trig      = 1'b0;
        trig_page = 8'h00;
    endtask

    // Count busy cycles and done pulses until idle; optionally retrigger at cycle retrig_at
    task automatic measure(input int retrig_at, input logic [7:0] retrig_page,
                           output int busy_cyc, output int done_cnt);
        int idle;
        busy_cyc = 0;
        done_cnt = 0;
        idle     = 0;
        for (int c = 0; c < 2000; c++) begin
            if (busy) busy_cyc++;
            else      idle++;
            if (done) done_cnt++;
            if (c == retrig_at) begin
                trig = 1'b1;
                trig_page = retrig_page;
            end else begin
                trig = 1'b0;
                trig_page = 8'h00;
            end
            if (idle >= 3) break;
            @(negedge clk);
        end
        if (busy) begin
            n_checks++;
            $display("FAIL transfer_timeout: got busy still high expected idle within 2000 cycles");
        end
    endtask

    task automatic check_oam(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < 160; i++)
            if (mem[16'hFE00 + 16'(i)] !== exp_oam[i]) bad++;
        check(name, bad, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int bc, dc;
        fill(8'hFE, 8'hEE);
        fill(v.src, v.xorv);
        if (v.page != v.src) fill(v.page, 8'hC3);
        push_bytes(v.xorv, 160, 1'b1);
        echo_hits  = 0;
        watch_page = v.page;
        watch_en   = (v.page != v.src);
        trigger(v.page);
        measure(-1, 8'h00, bc, dc);
        watch_en = 1'b0;
        check("busy_cycles", bc, 480);
        check("done_pulses", dc, 1);
        check("sb_drained", sb_q.size(), 0);
        check("echo_addr_hits", echo_hits, 0);
        check_oam("oam_contents");
    endtask

    vec_t vecs [4];

    initial begin
        int bc, dc;
        vecs[0] = '{page: 8'hC0, src: 8'hC0, xorv: 8'h5A};
        vecs[1] = '{page: 8'hE1, src: 8'hC1, xorv: 8'h00};
        vecs[2] = '{page: 8'hFF, src: 8'hDF, xorv: 8'hA5};
        vecs[3] = '{page: 8'h12, src: 8'h12, xorv: 8'h3C};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_we", bus.write_enable, 0);
        check("rst_addr", bus.addr_select, 16'h0000);
        check("rst_wdata", bus.write_value, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Cycle-accurate bus sequence for the first byte of page 0x80
        fill(8'hFE, 8'hEE);
        fill(8'h80, 8'h77);
        push_bytes(8'h77, 160, 1'b1);
        trigger(8'h80);
        check("seq_c1_addr", {bus.addr_select, 7'd0, bus.write_enable}, {16'h8000, 8'h00});
        @(negedge clk);
        check("seq_c2_addr", {bus.addr_select, 7'd0, bus.write_enable}, {16'h8000, 8'h00});
        @(negedge clk);
        check("seq_c3_wr", {bus.addr_select, bus.write_value, 7'd0, bus.write_enable},
              {16'hFE00, 8'h77, 8'h01});
        @(negedge clk);
        check("seq_c4_addr", bus.addr_select, 16'h8001);
        measure(-1, 8'h00, bc, dc);
        // cycles 0..2 were consumed by the sequence checks above
        check("seq_busy_cycles", bc, 477);
        check("seq_done_pulses", dc, 1);
        check("seq_sb_drained", sb_q.size(), 0);
        check_oam("seq_oam_contents");

        // Table-driven transfers, including echo remap
        for (int v = 0; v < 4; v++) run_vec(vecs[v]);

        // Retrigger with page 0xD0 sampled at edge T0+100 (bytes 0..32 already written)
        fill(8'hFE, 8'hEE);
        fill(8'hC3, 8'h21);
        fill(8'hD0, 8'h6C);
`ifdef OAM_DMA_RESTART_EN
        push_bytes(8'h21, 33, 1'b0);
        push_bytes(8'h6C, 160, 1'b1);
`else
        push_bytes(8'h21, 160, 1'b1);
`endif
        trigger(8'hC3);
        measure(99, 8'hD0, bc, dc);
`ifdef OAM_DMA_RESTART_EN
        check("retrig_busy_cycles", bc, 580);
`else
        check("retrig_busy_cycles", bc, 480);
`endif
        check("retrig_done_pulses", dc, 1);
        check("retrig_sb_drained", sb_q.size(), 0);
        check_oam("retrig_oam_contents");

        // Reset during the WR cycle of byte 66
        fill(8'hFE, 8'hEE);
        fill(8'hC2, 8'h11);
        push_bytes(8'h11, 67, 1'b0);
        for (int i = 0; i < 160; i++) exp_oam[i] = (i < 66) ? (8'(i) ^ 8'h11) : (8'(i) ^ 8'hEE);
        trigger(8'hC2);
        repeat (200) @(negedge clk);
        check("pre_rst_we", bus.write_enable, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_we", bus.write_enable, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_addr", bus.addr_select, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_sb_drained", sb_q.size(), 0);
        check_oam("mid_rst_oam_contents");

        // Normal transfer after reset release
        run_vec(vecs[2]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
